data_cache_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the memory access stage and the data memory model, directly downstream of it.
  - Takes the memory access stage's word address, store data and read/write strobes.
  - Returns load data and a busywait that stalls the pipeline.
- Refills and evicts 128-bit blocks over a request/busywait handshake with data memory.

---
 rtl/data_cache_wb_if.sv | 28 ++
 rtl/data_cache_wb.sv | 147 ++++++++++++++
 tb/tb_data_cache_wb.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_wb_if.sv
// Block-transfer bus between the L1 data cache and the data memory model.
// The cache is the master; memory answers with mem_busywait / mem_readdata.
interface data_cache_wb_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_writedata,
        input  mem_readdata,
        input  mem_busywait
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_writedata,
        output mem_readdata,
        output mem_busywait
    );
endinterface

// File: rtl/data_cache_wb.sv
// Direct-mapped write-back, write-allocate L1 data cache, 8 lines x 16 B.
// Define DATA_CACHE_STATS_EN to add hit_count / miss_count outputs.
module data_cache_wb (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait,
`ifdef DATA_CACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    data_cache_wb_if.master mem
);
    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0]   valid;
    logic [7:0]   dirty;
    logic [24:0]  tag_mem  [8];
    logic [127:0] data_mem [8];

    logic [24:0] tag;
    logic [2:0]  index;
    logic [1:0]  word;
    logic [6:0]  word_lsb;
    logic        req;
    logic        hit;
    logic        complete;
    logic        fill;
    logic        unused_byte;

    assign tag         = address[31:7];
    assign index       = address[6:4];
    assign word        = address[3:2];
    assign word_lsb    = {word, 5'b0};
    assign unused_byte = ^address[1:0];

    assign req      = read | write;
    assign hit      = valid[index] && (tag_mem[index] == tag);
    assign complete = (state == IDLE) && req && hit;
    assign fill     = (state == FETCH) && !mem.mem_busywait;

    assign busywait = req && !((state == IDLE) && hit);
    assign readdata = (read && complete) ? data_mem[index][word_lsb +: 32] : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state        = state;
        mem.mem_read      = 1'b0;
        mem.mem_write     = 1'b0;
        mem.mem_address   = 28'd0;
        mem.mem_writedata = 128'd0;
        unique case (state)
            IDLE: begin
                if (req && !hit) begin
                    if (valid[index] && dirty[index]) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                mem.mem_write     = 1'b1;
                mem.mem_address   = {tag_mem[index], index};
                mem.mem_writedata = data_mem[index];
                if (!mem.mem_busywait) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                mem.mem_read    = 1'b1;
                mem.mem_address = address[31:4];
                if (!mem.mem_busywait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Only valid/dirty are reset; stale tags and data are masked by valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 8'd0;
            dirty <= 8'd0;
        end else if (fill) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (complete && write) begin
            dirty[index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (fill) begin
                tag_mem[index]  <= tag;
                data_mem[index] <= mem.mem_readdata;
            end else if (complete && write) begin
                data_mem[index][word_lsb +: 32] <= writedata;
            end
        end
    end

`ifdef DATA_CACHE_STATS_EN
    // A completion right after a refill belongs to the miss, not a hit.
    logic refilled;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
            refilled   <= 1'b0;
        end else begin
            if ((state == IDLE) && (next_state != IDLE)) begin
                miss_count <= miss_count + 32'd1;
            end
            if (complete && !refilled) begin
                hit_count <= hit_count + 32'd1;
            end
            if (fill) begin
                refilled <= 1'b1;
            end else if (complete) begin
                refilled <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_data_cache_wb.sv
// Bench for data_cache_wb: directed plan steps, then random loads/stores
// checked against a word-level memory image and a line-ownership model.
module tb_data_cache_wb;
    logic        clock = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    data_cache_wb_if mbus ();

    data_cache_wb dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait),
`ifdef DATA_CACHE_STATS_EN
        .hit_count (hit_count),
        .miss_count(miss_count),
`endif
        .mem       (mbus)
    );

    always #5 clock = ~clock;

    // Memory responder: holds mem_busywait for lat cycles per transfer.
    logic [127:0] mem_arr [64];
    bit           init_req = 1'b0;
    int           lat = 0;
    int           wcnt = 0;
    int           fills = 0;
    int           wbs = 0;
    int           both_high = 0;
    logic         mreq;

    assign mreq = mbus.mem_read | mbus.mem_write;
    assign mbus.mem_busywait = mreq && (wcnt < lat);
    assign mbus.mem_readdata =
        mbus.mem_read ? mem_arr[mbus.mem_address[5:0]] : 128'd0;

    always @(posedge clock) begin
        if (init_req) begin
            for (int i = 0; i < 64; i++) begin
                mem_arr[i] <= {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            wcnt <= 0;
        end else begin
            if (mreq && mbus.mem_busywait) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (mbus.mem_write && !mbus.mem_busywait) begin
                mem_arr[mbus.mem_address[5:0]] <= mbus.mem_writedata;
                wbs <= wbs + 1;
            end
            if (mbus.mem_read && !mbus.mem_busywait) fills <= fills + 1;
            if (mbus.mem_read && mbus.mem_write) both_high <= both_high + 1;
        end
    end

    // Reference model: CPU-visible word image plus which block each line holds.
    logic [31:0] ref_word [256];
    bit          ref_valid [8];
    bit          ref_dirty [8];
    int          ref_blk [8];
    int          exp_hits = 0;
    int          exp_misses = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 64; b++) begin
            for (int w = 0; w < 4; w++) begin
                ref_word[b*4+w] = mem_arr[b][w*32 +: 32];
            end
        end
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_blk[i]   = -1;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    function automatic logic [31:0] addr_of(input int blk, input int wd);
        logic [5:0] b6;
        logic [1:0] w2;
        b6 = blk[5:0];
        w2 = wd[1:0];
        return {22'd0, b6, w2, 2'b00};
    endfunction

    task automatic access(input bit rd, input bit wr, input int blk,
                          input int wd, input logic [31:0] data,
                          input int lat_v);
        int           idx;
        int           old;
        bit           exp_hit;
        bit           exp_wb;
        int           exp_stall;
        int           stall;
        int           fills0;
        int           wbs0;
        logic [127:0] wb_block;
        idx      = blk % 8;
        old      = ref_blk[idx];
        exp_hit  = ref_valid[idx] && (old == blk);
        exp_wb   = !exp_hit && ref_valid[idx] && ref_dirty[idx];
        wb_block = 128'd0;
        if (exp_wb) begin
            for (int w = 0; w < 4; w++) wb_block[w*32 +: 32] = ref_word[old*4+w];
        end
        exp_stall = exp_hit ? 0 : 1 + (lat_v + 1) + (exp_wb ? lat_v + 1 : 0);

        @(negedge clock);
        lat       = lat_v;
        read      = rd;
        write     = wr;
        address   = addr_of(blk, wd);
        writedata = data;
        fills0    = fills;
        wbs0      = wbs;
        #1;
        chk("busy_first", busywait, !exp_hit);
        stall = 0;
        while (busywait && stall < 100) begin
            if (mbus.mem_write) begin
                chk("wb_addr", mbus.mem_address, old);
                chk("wb_data", mbus.mem_writedata, wb_block);
                chk("wb_excl", mbus.mem_read, 1'b0);
            end
            if (mbus.mem_read) begin
                chk("fetch_addr", mbus.mem_address, blk);
                chk("fetch_excl", mbus.mem_write, 1'b0);
            end
            stall++;
            @(negedge clock);
        end
        chk("stall_cycles", stall, exp_stall);
        chk("fill_count", fills - fills0, exp_hit ? 0 : 1);
        chk("wb_count", wbs - wbs0, exp_wb ? 1 : 0);
        chk("idle_mem_read", mbus.mem_read, 1'b0);
        chk("idle_mem_write", mbus.mem_write, 1'b0);
        chk("idle_mem_addr", mbus.mem_address, 28'd0);
        chk("idle_mem_wdata", mbus.mem_writedata, 128'd0);
        if (rd && !wr) chk("readdata", readdata, ref_word[blk*4+wd]);
        else chk("readdata_zero", readdata, 32'd0);

        if (exp_hit) begin
            exp_hits++;
        end else begin
            exp_misses++;
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
            ref_blk[idx]   = blk;
        end
        if (wr) begin
            ref_word[blk*4+wd] = data;
            ref_dirty[idx]     = 1'b1;
        end
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic chk_stats();
`ifdef DATA_CACHE_STATS_EN
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
`endif
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        init_req  = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = 32'd0;
        writedata = 32'd0;
        repeat (2) @(negedge clock);
        chk("rst_busywait", busywait, 1'b0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_mem_read", mbus.mem_read, 1'b0);
        chk("rst_mem_write", mbus.mem_write, 1'b0);
        init_req = 1'b0;
        reset    = 1'b0;
        model_reset();
        chk_stats();

        // Clean miss on 0x40, then write/read hits on the same line.
        access(1, 0, 4, 0, 32'd0, 0);
        access(0, 1, 4, 1, 32'hDEADBEEF, 0);
        access(1, 0, 4, 1, 32'd0, 0);
        access(1, 0, 4, 0, 32'd0, 0);
        chk("dirty_line_data", ref_word[17], 32'hDEADBEEF);
        chk_stats();

        // 0xC4 evicts dirty block 4, then a slow 5-cycle fetch.
        access(1, 0, 12, 1, 32'd0, 0);
        chk("wb_landed", mem_arr[4][63:32], 32'hDEADBEEF);
        access(1, 0, 20, 3, 32'd0, 5);

        // Reset while a writeback is pending discards the dirty word.
        access(0, 1, 20, 2, 32'hCAFEF00D, 0);
        @(negedge clock);
        lat     = 5;
        read    = 1'b1;
        address = addr_of(28, 0);
        n = 0;
        while (!mbus.mem_write && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("wb_started", mbus.mem_write, 1'b1);
        reset = 1'b1;
        read  = 1'b0;
        @(negedge clock);
        chk("rst_wb_mem_write", mbus.mem_write, 1'b0);
        chk("rst_wb_mem_read", mbus.mem_read, 1'b0);
        chk("rst_wb_busywait", busywait, 1'b0);
        reset = 1'b0;
        model_reset();
        access(1, 0, 20, 2, 32'd0, 0);
        chk_stats();

        for (int i = 0; i < 200; i++) begin
            bit wr_r;
            wr_r = bit'($urandom_range(0, 1));
            access(!wr_r, wr_r, $urandom_range(0, 63), $urandom_range(0, 3),
                   $urandom(), $urandom_range(0, 3));
        end
        chk_stats();
        chk("never_both_high", both_high, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
